trigger_scaler_counter: RTL and testbench

Counting end of the per-channel scaler pulse stream. Takes the single-cycle `scaler_o` flags from the trigger front-ends, all on `fast_clk_i`, and accumulates one saturating counter per channel over a gate period. On each period strobe it snapshots every counter into a holding bank, restarts counting and flags the update. Software-facing logic reads the holding bank through a registered, addressed read port.

---
 rtl/trigger_scaler_counter.sv | 154 +++++++++++++++
 tb/tb_trigger_scaler_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_scaler_counter.sv
// Per-channel saturating scaler counters with a period-gated snapshot bank
// and a registered, addressed read port. Single clock domain.
module trigger_scaler_counter #(
    parameter int unsigned NCH       = 16,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned SEQ_BITS  = 8
) (
    input  logic                 fast_clk_i,
    input  logic                 rst_n_i,
    input  logic [NCH-1:0]       scaler_i,
    input  logic                 period_i,
    input  logic                 rd_req_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic                 rd_valid_o,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic                 rd_ovf_o,
    output logic                 update_o,
    output logic [SEQ_BITS-1:0]  seq_o,
    output logic                 first_o
);

    typedef enum logic [0:0] {StIdle, StLatch} state_e;

    localparam logic [WIDTH-1:0] CntMax = '1;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      cnt_q [NCH];
    logic [WIDTH-1:0]      cnt_d [NCH];
    logic [NCH-1:0]        ovf_q, ovf_d;
    logic [WIDTH-1:0]      hold_q [NCH];
    logic [NCH-1:0]        hold_ovf_q;
    logic                  rd_valid_q;
    logic [WIDTH-1:0]      rd_data_q, rd_sel_data;
    logic                  rd_ovf_q, rd_sel_ovf;
    logic                  update_q, update_d;
    logic [SEQ_BITS-1:0]   seq_q, seq_d;
    logic                  first_q, first_d;

    // A pulse on the latch edge starts the new period rather than closing the old one.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (period_i) begin
                cnt_d[k] = scaler_i[k] ? WIDTH'(1) : '0;
                ovf_d[k] = 1'b0;
            end else if (scaler_i[k]) begin
                if (cnt_q[k] == CntMax) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NCH; k++) begin
                hold_q[k] <= '0;
            end
            hold_ovf_q <= '0;
        end else if (period_i) begin
            for (int k = 0; k < NCH; k++) begin
                hold_q[k] <= cnt_q[k];
            end
            hold_ovf_q <= ovf_q;
        end
    end

    // Addresses beyond NCH match no channel and read as zero.
    always_comb begin
        rd_sel_data = '0;
        rd_sel_ovf  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_addr_i == ADDR_BITS'(k)) begin
                rd_sel_data = hold_q[k];
                rd_sel_ovf  = hold_ovf_q[k];
            end
        end
    end

    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_sel_data;
                rd_ovf_q  <= rd_sel_ovf;
            end
        end
    end

    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A strobe seen in either state starts a fresh latch.
    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle:  state_d = period_i ? StLatch : StIdle;
            StLatch: state_d = period_i ? StLatch : StIdle;
        endcase
    end

    always_comb begin
        update_d = (state_q == StLatch);
        seq_d    = update_d ? seq_q + SEQ_BITS'(1) : seq_q;
        first_d  = update_d ? 1'b0 : first_q;
    end

    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            update_q <= 1'b0;
            seq_q    <= '0;
            first_q  <= 1'b1;
        end else begin
            update_q <= update_d;
            seq_q    <= seq_d;
            first_q  <= first_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_ovf_o   = rd_ovf_q;
    assign update_o   = update_q;
    assign seq_o      = seq_q;
    assign first_o    = first_q;

endmodule

// File: tb/tb_trigger_scaler_counter.sv
// Directed bench: a default-size instance plus a narrow (8 ch, 4-bit) instance
// sharing the same stimulus, exercising saturation and out-of-range reads.
module tb_trigger_scaler_counter;

    logic        clk;
    logic        rst_n;
    logic [15:0] scaler;
    logic        period;
    logic        rd_req;
    logic [3:0]  rd_addr;

    logic        rd_valid, rd_ovf, update, first;
    logic [15:0] rd_data;
    logic [7:0]  seq;

    logic        n_rd_valid, n_rd_ovf, n_update, n_first;
    logic [3:0]  n_rd_data;
    logic [7:0]  n_seq;

    int checks = 0;
    int errors = 0;
    int exp_seq = 0;

    trigger_scaler_counter u_dut (
        .fast_clk_i (clk),
        .rst_n_i    (rst_n),
        .scaler_i   (scaler),
        .period_i   (period),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .rd_ovf_o   (rd_ovf),
        .update_o   (update),
        .seq_o      (seq),
        .first_o    (first)
    );

    trigger_scaler_counter #(
        .NCH       (8),
        .WIDTH     (4),
        .ADDR_BITS (4),
        .SEQ_BITS  (8)
    ) u_narrow (
        .fast_clk_i (clk),
        .rst_n_i    (rst_n),
        .scaler_i   (scaler[7:0]),
        .period_i   (period),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_valid_o (n_rd_valid),
        .rd_data_o  (n_rd_data),
        .rd_ovf_o   (n_rd_ovf),
        .update_o   (n_update),
        .seq_o      (n_seq),
        .first_o    (n_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            scaler[ch] = 1'b1;
            tick();
        end
        scaler = '0;
    endtask

    task automatic strobe();
        period = 1'b1;
        tick();
        period = 1'b0;
        exp_seq++;
    endtask

    task automatic read(input int a);
        rd_req  = 1'b1;
        rd_addr = 4'(a);
        tick();
        rd_req  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        scaler  = '0;
        period  = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_update", update, 0);
        check("rst_seq", seq, 0);
        check("rst_first", first, 1);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_ovf", rd_ovf, 0);
        rst_n = 1'b1;
        tick();

        // Basic count and snapshot
        pulses(3, 37);
        strobe();
        check("upd_early", update, 0);
        check("first_before_upd", first, 1);
        tick();
        check("upd_pulse", update, 1);
        check("seq_first", seq, exp_seq);
        check("first_fall", first, 0);
        tick();
        check("upd_one_cycle", update, 0);
        read(4);
        check("rd4_valid", rd_valid, 1);
        check("rd4_data", rd_data, 0);
        read(3);
        check("rd3_valid", rd_valid, 1);
        check("rd3_data", rd_data, 37);
        check("rd3_ovf", rd_ovf, 0);
        check("n_rd3_data", n_rd_data, 15);
        check("n_rd3_ovf", n_rd_ovf, 1);
        tick();
        check("rd_valid_drop", rd_valid, 0);
        check("rd_data_hold", rd_data, 37);
        read(12);
        check("n_oor_valid", n_rd_valid, 1);
        check("n_oor_data", n_rd_data, 0);
        check("n_oor_ovf", n_rd_ovf, 0);

        // Saturation on the narrow instance
        pulses(0, 20);
        strobe();
        read(0);
        check("sat_wide", rd_data, 20);
        check("sat_wide_ovf", rd_ovf, 0);
        check("sat_narrow", n_rd_data, 15);
        check("sat_narrow_ovf", n_rd_ovf, 1);
        pulses(0, 2);
        strobe();
        read(0);
        check("unsat_narrow", n_rd_data, 2);
        check("unsat_narrow_ovf", n_rd_ovf, 0);
        check("unsat_wide", rd_data, 2);

        // Pulse coincident with the latch edge belongs to the next period
        scaler[5] = 1'b1;
        strobe();
        scaler = '0;
        read(5);
        check("coinc_snap_k", rd_data, 0);
        strobe();
        read(5);
        check("coinc_snap_k1", rd_data, 1);

        // Read on the latch edge returns the previous snapshot
        pulses(2, 7);
        strobe();
        pulses(2, 3);
        period  = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 4'd2;
        tick();
        period  = 1'b0;
        rd_req  = 1'b0;
        exp_seq++;
        check("rd_on_latch_old", rd_data, 7);
        read(2);
        check("rd_after_latch_new", rd_data, 3);
        tick();
        check("seq_mid", seq, exp_seq);

        // Back-to-back strobes
        pulses(1, 5);
        period = 1'b1;
        tick();
        rd_req  = 1'b1;
        rd_addr = 4'd1;
        tick();
        period = 1'b0;
        check("b2b_snap1", rd_data, 5);
        check("b2b_upd1", update, 1);
        check("b2b_seq1", seq, exp_seq + 1);
        tick();
        rd_req = 1'b0;
        check("b2b_snap2", rd_data, 0);
        check("b2b_upd2", update, 1);
        check("b2b_seq2", seq, exp_seq + 2);
        exp_seq += 2;
        tick();
        check("b2b_upd_end", update, 0);

        // Reset mid-period discards live counts
        pulses(6, 9);
        rst_n = 1'b0;
        exp_seq = 0;
        tick();
        check("mid_rst_seq", seq, 0);
        check("mid_rst_first", first, 1);
        rst_n = 1'b1;
        pulses(6, 4);
        check("partial_first", first, 1);
        strobe();
        check("partial_first_latch", first, 1);
        tick();
        check("partial_upd", update, 1);
        check("partial_seq", seq, exp_seq);
        check("partial_first_fall", first, 0);
        read(6);
        check("partial_snap", rd_data, 4);
        check("n_partial_snap", n_rd_data, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
